resp_fifo_writer: RTL and testbench
===================================

Name: resp_fifo_writer

Overview:
- Response scheduler between the register-file read port, the ALU result port and the TX async FIFO write port.
- Holds one pending response per source and arbitrates round-robin between them.
- Serialises the 16-bit ALU result into two bytes, low byte first.
- Honours FIFO_FULL back-pressure and reports a sticky overflow error.

Parameters:
DATA_WIDTH, 8, FIFO byte width and register-file data width.
ALU_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH.

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-low
RdData  input  DATA_WIDTH  register-file read data
RdData_valid  input  1  one-cycle pulse, RdData valid
ALU_OUT  input  ALU_WIDTH  ALU result
OUT_valid  input  1  one-cycle pulse, ALU_OUT valid
FIFO_FULL  input  1  TX FIFO full, synchronous to CLK
ERR_CLR  input  1  clears OVF_ERR
WR_DATA_FIFO  output  DATA_WIDTH  FIFO write data
WR_INC  output  1  FIFO write strobe, one byte per high cycle
RF_HOLD_FULL  output  1  register-file holding slot occupied
ALU_HOLD_FULL  output  1  ALU holding slot occupied
RESP_IDLE  output  1  FSM in IDLE and both slots empty
OVF_ERR  output  1  sticky: a valid pulse was dropped

Behaviour:
- Reset values (async, RST low):
  - all outputs 0, except RESP_IDLE=1.
  - FSM=IDLE, both slots empty, last_grant=ALU (so RF wins the first tie).
  - A partially sent ALU word is lost: low byte already in the FIFO, high byte never sent.
- Capture:
  - RdData_valid with the RF slot empty latches RdData at that edge.
  - OUT_valid with the ALU slot empty latches ALU_OUT at that edge.
  - A slot freed by its final byte write in the same cycle counts as empty, so capture proceeds.
  - A valid pulse into a full slot is dropped. Slot contents are unchanged and OVF_ERR is set at that edge.
  - OVF_ERR clears only on ERR_CLR. If set and clear occur together, set wins.
- FSM, states IDLE, RF_BYTE, ALU_LO, ALU_HI, state register only:
  - IDLE, only RF slot full -> RF_BYTE.
  - IDLE, only ALU slot full -> ALU_LO.
  - IDLE, both full -> grant the source other than last_grant; last_grant updates on grant.
  - IDLE, both empty -> stay.
  - RF_BYTE: FIFO_FULL=0 -> write RF byte, free RF slot, -> IDLE. FIFO_FULL=1 -> stay.
  - ALU_LO: FIFO_FULL=0 -> write ALU_OUT[7:0], -> ALU_HI. FIFO_FULL=1 -> stay.
  - ALU_HI: FIFO_FULL=0 -> write ALU_OUT[15:8], free ALU slot, -> IDLE. FIFO_FULL=1 -> stay.
  - The ALU word is never interrupted: no RF byte is inserted between its low and high bytes.
- Outputs:
  - WR_INC = (state != IDLE) && !FIFO_FULL, decoded combinationally from the state register and FIFO_FULL.
  - WR_DATA_FIFO = selected byte in the write states, 0 in IDLE.
  - Data is stable while stalled.
- Latency:
  - valid pulse in cycle 0 -> capture at end of cycle 0 -> grant in cycle 1 -> first WR_INC in cycle 2 if the FIFO is not full.
  - The ALU high byte follows in cycle 3.
- Throughput: one IDLE bubble after each response, so a steady RF stream produces 1 byte per 2 cycles.
- A FIFO_FULL stall has no timeout and never reorders or drops bytes.

Decomposition:
- Shared package: state encoding (IDLE/RF_BYTE/ALU_LO/ALU_HI, 2-bit), grant encoding (GNT_RF/GNT_ALU), DATA_WIDTH/ALU_WIDTH defaults.
- One sub-module, resp_hold_slot, parameterised by width and instantiated twice:
  - inputs: data, valid, free.
  - outputs: held data, full, overflow pulse.

Test Plan:
- RdData=8'h5A pulse at cycle 0, FIFO_FULL=0 -> WR_INC=1 with WR_DATA_FIFO=8'h5A in cycle 2 only. RF_HOLD_FULL high in cycles 1-2, RESP_IDLE=1 from cycle 3.
- ALU_OUT=16'hBEEF pulse -> two WR_INC cycles: 8'hEF, then 8'hBE, consecutive. ALU_HOLD_FULL drops after the second.
- RdData_valid (8'h11) and OUT_valid (16'h2233) in the same cycle after reset -> FIFO receives 11, 33, 22. Repeat with RdData 8'h44 / ALU_OUT 16'h5566 -> 66, 55, 44 (round-robin alternates).
- Sending 16'hA1B2 with FIFO_FULL=1 asserted during ALU_HI for 5 cycles -> B2 written, no WR_INC while full, WR_DATA_FIFO held at 8'hA1, A1 written the cycle FIFO_FULL drops.
- Second RdData_valid (8'h77) while the RF slot holds 8'h66 under FIFO_FULL -> OVF_ERR=1, only 66 written. ERR_CLR pulse -> OVF_ERR=0.
- RST low during ALU_HI of 16'hCAFE -> only FE in the FIFO. All outputs at reset values immediately, without a clock edge. Normal operation resumes after release.

Source files
------------

// File: rtl/resp_fifo_writer_pkg.sv
// Shared encodings and default widths for the response FIFO writer.
package resp_fifo_writer_pkg;

    localparam int RESP_DATA_WIDTH = 8;
    localparam int RESP_ALU_WIDTH  = 2 * RESP_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RF_BYTE = 2'd1,
        ST_ALU_LO  = 2'd2,
        ST_ALU_HI  = 2'd3
    } resp_state_e;

    typedef enum logic {
        GNT_RF  = 1'b0,
        GNT_ALU = 1'b1
    } resp_grant_e;

endpackage

// File: rtl/resp_fifo_writer_hold_slot.sv
// Single-entry holding register for one response source with drop detection.
module resp_hold_slot
    import resp_fifo_writer_pkg::*;
#(
    parameter int WIDTH = RESP_DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    input  logic             free,
    output logic [WIDTH-1:0] held,
    output logic             full,
    output logic             ovf
);

    logic full_q;
    logic accept;

    // A slot being drained by its last byte this cycle can take a new value.
    assign accept = valid && (!full_q || free);
    assign ovf    = valid && full_q && !free;
    assign full   = full_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_q <= 1'b0;
            held   <= '0;
        end else if (accept) begin
            full_q <= 1'b1;
            held   <= data;
        end else if (free) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/resp_fifo_writer.sv
// Round-robin response scheduler feeding RF bytes and split ALU words into the TX FIFO.
// state     | meaning
// IDLE      | no write in progress, arbitrating between slots
// RF_BYTE   | writing the held register-file byte
// ALU_LO    | writing the ALU result low byte
// ALU_HI    | writing the ALU result high byte, then freeing the ALU slot
module resp_fifo_writer
    import resp_fifo_writer_pkg::*;
#(
    parameter int DATA_WIDTH = RESP_DATA_WIDTH,
    parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_valid,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_valid,
    input  logic                  FIFO_FULL,
    input  logic                  ERR_CLR,
    output logic [DATA_WIDTH-1:0] WR_DATA_FIFO,
    output logic                  WR_INC,
    output logic                  RF_HOLD_FULL,
    output logic                  ALU_HOLD_FULL,
    output logic                  RESP_IDLE,
    output logic                  OVF_ERR
);

    resp_state_e           state;
    resp_grant_e           last_grant;
    logic [DATA_WIDTH-1:0] rf_held;
    logic [ALU_WIDTH-1:0]  alu_held;
    logic                  rf_full, alu_full;
    logic                  rf_ovf, alu_ovf;
    logic                  rf_free, alu_free;

    assign rf_free  = (state == ST_RF_BYTE) && !FIFO_FULL;
    assign alu_free = (state == ST_ALU_HI) && !FIFO_FULL;

    resp_hold_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
        .CLK   (CLK),
        .RST   (RST),
        .data  (RdData),
        .valid (RdData_valid),
        .free  (rf_free),
        .held  (rf_held),
        .full  (rf_full),
        .ovf   (rf_ovf)
    );

    resp_hold_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
        .CLK   (CLK),
        .RST   (RST),
        .data  (ALU_OUT),
        .valid (OUT_valid),
        .free  (alu_free),
        .held  (alu_held),
        .full  (alu_full),
        .ovf   (alu_ovf)
    );

    // last_grant only moves on a contested grant, so uncontested traffic
    // does not disturb the alternation between simultaneous requests.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            last_grant <= GNT_ALU;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rf_full && alu_full) begin
                        if (last_grant == GNT_ALU) begin
                            state      <= ST_RF_BYTE;
                            last_grant <= GNT_RF;
                        end else begin
                            state      <= ST_ALU_LO;
                            last_grant <= GNT_ALU;
                        end
                    end else if (rf_full) begin
                        state <= ST_RF_BYTE;
                    end else if (alu_full) begin
                        state <= ST_ALU_LO;
                    end
                end
                ST_RF_BYTE: if (!FIFO_FULL) state <= ST_IDLE;
                ST_ALU_LO:  if (!FIFO_FULL) state <= ST_ALU_HI;
                ST_ALU_HI:  if (!FIFO_FULL) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OVF_ERR <= 1'b0;
        end else if (rf_ovf || alu_ovf) begin
            OVF_ERR <= 1'b1;
        end else if (ERR_CLR) begin
            OVF_ERR <= 1'b0;
        end
    end

    always_comb begin
        WR_DATA_FIFO = '0;
        case (state)
            ST_RF_BYTE: WR_DATA_FIFO = rf_held;
            ST_ALU_LO:  WR_DATA_FIFO = alu_held[DATA_WIDTH-1:0];
            ST_ALU_HI:  WR_DATA_FIFO = alu_held[ALU_WIDTH-1:DATA_WIDTH];
            default:    WR_DATA_FIFO = '0;
        endcase
    end

    assign WR_INC        = (state != ST_IDLE) && !FIFO_FULL;
    assign RF_HOLD_FULL  = rf_full;
    assign ALU_HOLD_FULL = alu_full;
    assign RESP_IDLE     = (state == ST_IDLE) && !rf_full && !alu_full;

endmodule

// File: tb/tb_resp_fifo_writer.sv
// Directed bench for resp_fifo_writer with a byte scoreboard on the FIFO write port.
module tb_resp_fifo_writer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RdData;
    logic        RdData_valid;
    logic [15:0] ALU_OUT;
    logic        OUT_valid;
    logic        FIFO_FULL;
    logic        ERR_CLR;
    logic [7:0]  WR_DATA_FIFO;
    logic        WR_INC;
    logic        RF_HOLD_FULL;
    logic        ALU_HOLD_FULL;
    logic        RESP_IDLE;
    logic        OVF_ERR;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];

    resp_fifo_writer #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RdData        (RdData),
        .RdData_valid  (RdData_valid),
        .ALU_OUT       (ALU_OUT),
        .OUT_valid     (OUT_valid),
        .FIFO_FULL     (FIFO_FULL),
        .ERR_CLR       (ERR_CLR),
        .WR_DATA_FIFO  (WR_DATA_FIFO),
        .WR_INC        (WR_INC),
        .RF_HOLD_FULL  (RF_HOLD_FULL),
        .ALU_HOLD_FULL (ALU_HOLD_FULL),
        .RESP_IDLE     (RESP_IDLE),
        .OVF_ERR       (OVF_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every byte written must be the next expected one.
    always @(negedge CLK) begin
        if (RST && WR_INC) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_byte: got unexpected %h, expected none at %0t", WR_DATA_FIFO, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (WR_DATA_FIFO !== e) begin
                    n_fail++;
                    $display("FAIL fifo_byte: got %h expected %h at %0t", WR_DATA_FIFO, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (exp_q.size() == 0 && RESP_IDLE) done = 1'b1;
        end
        check(name, {15'd0, done}, 16'd1);
    endtask

    task automatic wait_byte(input logic [7:0] b, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (WR_INC && WR_DATA_FIFO == b) found = 1'b1;
        end
        check(name, {15'd0, found}, 16'd1);
    endtask

    initial begin
        RST = 1'b0; RdData = '0; RdData_valid = 1'b0; ALU_OUT = '0;
        OUT_valid = 1'b0; FIFO_FULL = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_wr_inc", {15'd0, WR_INC}, 16'd0);
        check("rst_data", {8'd0, WR_DATA_FIFO}, 16'd0);
        check("rst_idle", {15'd0, RESP_IDLE}, 16'd1);
        check("rst_ovf", {15'd0, OVF_ERR}, 16'd0);
        RST = 1'b1;
        tick();

        // Single RF byte, cycle-accurate latency
        RdData = 8'h5A; RdData_valid = 1'b1; exp_q.push_back(8'h5A);
        @(negedge CLK);
        check("rf_c0_full", {15'd0, RF_HOLD_FULL}, 16'd0);
        tick(); RdData_valid = 1'b0;
        @(negedge CLK);
        check("rf_c1_full", {15'd0, RF_HOLD_FULL}, 16'd1);
        check("rf_c1_inc", {15'd0, WR_INC}, 16'd0);
        check("rf_c1_idle", {15'd0, RESP_IDLE}, 16'd0);
        tick();
        @(negedge CLK);
        check("rf_c2_inc", {15'd0, WR_INC}, 16'd1);
        check("rf_c2_data", {8'd0, WR_DATA_FIFO}, 16'h5A);
        check("rf_c2_full", {15'd0, RF_HOLD_FULL}, 16'd1);
        tick();
        @(negedge CLK);
        check("rf_c3_inc", {15'd0, WR_INC}, 16'd0);
        check("rf_c3_full", {15'd0, RF_HOLD_FULL}, 16'd0);
        check("rf_c3_idle", {15'd0, RESP_IDLE}, 16'd1);
        tick();

        // ALU word, low byte then high byte on consecutive cycles
        ALU_OUT = 16'hBEEF; OUT_valid = 1'b1;
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        tick(); OUT_valid = 1'b0;
        tick();
        @(negedge CLK);
        check("alu_c2_inc", {15'd0, WR_INC}, 16'd1);
        check("alu_c2_data", {8'd0, WR_DATA_FIFO}, 16'hEF);
        tick();
        @(negedge CLK);
        check("alu_c3_inc", {15'd0, WR_INC}, 16'd1);
        check("alu_c3_data", {8'd0, WR_DATA_FIFO}, 16'hBE);
        check("alu_c3_full", {15'd0, ALU_HOLD_FULL}, 16'd1);
        tick();
        @(negedge CLK);
        check("alu_c4_full", {15'd0, ALU_HOLD_FULL}, 16'd0);
        check("alu_c4_inc", {15'd0, WR_INC}, 16'd0);
        drain("drain_alu");

        // Simultaneous requests: RF wins first, then ALU wins the next tie
        RdData = 8'h11; RdData_valid = 1'b1; ALU_OUT = 16'h2233; OUT_valid = 1'b1;
        exp_q.push_back(8'h11); exp_q.push_back(8'h33); exp_q.push_back(8'h22);
        tick(); RdData_valid = 1'b0; OUT_valid = 1'b0;
        drain("drain_tie1");
        RdData = 8'h44; RdData_valid = 1'b1; ALU_OUT = 16'h5566; OUT_valid = 1'b1;
        exp_q.push_back(8'h66); exp_q.push_back(8'h55); exp_q.push_back(8'h44);
        tick(); RdData_valid = 1'b0; OUT_valid = 1'b0;
        drain("drain_tie2");

        // Stall during the high byte for 5 cycles
        ALU_OUT = 16'hA1B2; OUT_valid = 1'b1;
        exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
        tick(); OUT_valid = 1'b0;
        wait_byte(8'hB2, "stall_lo_seen");
        tick(); FIFO_FULL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_inc", {15'd0, WR_INC}, 16'd0);
            check("stall_data", {8'd0, WR_DATA_FIFO}, 16'hA1);
            tick();
        end
        FIFO_FULL = 1'b0;
        @(negedge CLK);
        check("stall_rel_inc", {15'd0, WR_INC}, 16'd1);
        check("stall_rel_data", {8'd0, WR_DATA_FIFO}, 16'hA1);
        drain("drain_stall");

        // Overflow into a full RF slot, clear, and set-wins-over-clear
        FIFO_FULL = 1'b1; RdData = 8'h66; RdData_valid = 1'b1; exp_q.push_back(8'h66);
        tick(); RdData_valid = 1'b0;
        @(negedge CLK);
        check("ovf_slot_full", {15'd0, RF_HOLD_FULL}, 16'd1);
        check("ovf_before", {15'd0, OVF_ERR}, 16'd0);
        tick(); RdData = 8'h77; RdData_valid = 1'b1;
        tick(); RdData_valid = 1'b0;
        @(negedge CLK);
        check("ovf_set", {15'd0, OVF_ERR}, 16'd1);
        check("ovf_held_data", {8'd0, WR_DATA_FIFO}, 16'h66);
        tick(); ERR_CLR = 1'b1;
        tick(); ERR_CLR = 1'b0;
        @(negedge CLK);
        check("ovf_clr", {15'd0, OVF_ERR}, 16'd0);
        tick(); RdData = 8'h88; RdData_valid = 1'b1; ERR_CLR = 1'b1;
        tick(); RdData_valid = 1'b0; ERR_CLR = 1'b0;
        @(negedge CLK);
        check("ovf_set_wins", {15'd0, OVF_ERR}, 16'd1);
        tick(); ERR_CLR = 1'b1;
        tick(); ERR_CLR = 1'b0;
        @(negedge CLK);
        check("ovf_clr2", {15'd0, OVF_ERR}, 16'd0);
        tick(); FIFO_FULL = 1'b0;
        drain("drain_ovf");

        // Async reset in the middle of an ALU word drops the high byte
        ALU_OUT = 16'hCAFE; OUT_valid = 1'b1; exp_q.push_back(8'hFE);
        tick(); OUT_valid = 1'b0;
        wait_byte(8'hFE, "rst_lo_seen");
        tick(); RST = 1'b0;
        #1;
        check("rst_mid_inc", {15'd0, WR_INC}, 16'd0);
        check("rst_mid_data", {8'd0, WR_DATA_FIFO}, 16'd0);
        check("rst_mid_alu", {15'd0, ALU_HOLD_FULL}, 16'd0);
        check("rst_mid_idle", {15'd0, RESP_IDLE}, 16'd1);
        repeat (3) tick();
        RST = 1'b1;
        tick();
        RdData = 8'h3C; RdData_valid = 1'b1; exp_q.push_back(8'h3C);
        tick(); RdData_valid = 1'b0;
        drain("drain_resume");
        check("final_queue", exp_q.size(), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
